video_fetch_arbiter: RTL
========================

// Module: video_fetch_arbiter
// PURPOSE
//  Schedules framebuffer reads for the 1080p HDMI scan-out and shares one memory port with a pixel writer.
//  Per line it burst-reads LINE_WORDS words into a ping-pong line buffer ahead of the active region.
//  Scan-out fetches have strict priority over the writer. Sits between the HDMI timing generator and external RAM.
// PARAMETERS
//  ADDR_W      24   memory word-address width
//  DATA_W      32   memory data width (4 px x 8 bit)
//  LINE_WORDS  480  words per line (1920 px / 4)
//  FB_BASE     0    framebuffer base word address
//  LB_AW       9    line-buffer address width per bank; 2**LB_AW >= LINE_WORDS
// PORTS
//  hdmi_clk     in   1        pixel clock; sole clock
//  reset_n      in   1        asynchronous, active-low reset
//  fetch_start  in   1        1-cycle pulse: begin fetch of fetch_line
//  fetch_line   in   12       line index, sampled with fetch_start
//  next_frame   in   1        1-cycle frame-boundary pulse; clears underrun_cnt
//  wr_valid     in   1        writer request
//  wr_addr      in   ADDR_W   writer word address
//  wr_data      in   DATA_W   writer data
//  wr_ready     out  1        writer request accepted this cycle
//  mem_valid    out  1        memory command valid (registered)
//  mem_we       out  1        1 = write, 0 = read
//  mem_addr     out  ADDR_W   command address
//  mem_wdata    out  DATA_W   write data
//  mem_ready    in   1        command accepted when mem_valid && mem_ready
//  mem_rvalid   in   1        read data valid; reads return in order
//  mem_rdata    in   DATA_W   read data
//  lb_we        out  1        line-buffer write strobe
//  lb_waddr     out  LB_AW+1  {bank, word index}
//  lb_wdata     out  DATA_W   = mem_rdata, registered
//  lb_rd_bank   out  1        bank holding last completed line
//  fetch_done   out  1        1-cycle pulse: fetch complete
//  underrun     out  1        1-cycle pulse: fetch_start while fetch busy
//  underrun_cnt out  8        saturating underrun count
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; bank=0; counters 0. Reset mid-fetch abandons it; rvalids arriving after reset are ignored.
//  FSM IDLE/FETCH/WRITE. Memory command regs hold payload stable while mem_valid && !mem_ready.
//  IDLE: fetch pending -> FETCH; else wr_valid -> latch writer into command regs (mem_we=1), wr_ready=1 for that cycle -> WRITE.
//  WRITE: on accept, drop mem_valid -> IDLE; a single write, never preempted.
//  FETCH: issue reads at FB_BASE + fetch_line*LINE_WORDS + i, i=0..LINE_WORDS-1, one per accepted cycle (back-to-back when
//   mem_ready=1). After last accept -> IDLE; writer may be granted while reads are still outstanding.
//  fetch_start in any state: if no fetch active/pending, latch line, toggle bank, set pending (first fetch uses bank 0).
//   Else: underrun=1 next cycle, underrun_cnt+1 saturating at 255, request dropped, current fetch unaffected.
//  Fetch active = pending, issuing, or rvalids outstanding (issued != received).
//  mem_rvalid: lb_we=1 one cycle later, lb_waddr={bank, rx index}, lb_wdata=mem_rdata. Ignored if no reads outstanding.
//  fetch_done pulses the cycle after the LINE_WORDS-th lb_we; lb_rd_bank <= fetch bank on the same edge.
//  next_frame clears underrun_cnt; an underrun on the same cycle yields cnt=1.
//  Address arithmetic modulo 2**ADDR_W; fetch_line*LINE_WORDS uses full ADDR_W width.
//  wr_ready never asserts while a fetch is pending or issuing; the writer holds its request until wr_ready.
// TESTING
//  1 Reset: reset_n=0 mid-traffic -> all outputs 0 asynchronously; FSM=IDLE after release.
//  2 fetch_line=5, mem_ready=1, 2-cycle read latency -> reads 2400..2879 back-to-back, lb_waddr 0..479 bank0, one fetch_done, lb_rd_bank=0.
//  3 wr_valid held during fetch -> wr_ready=0 until the 480th read is accepted; then 1 write with mem_we=1 and correct addr/data.
//  4 fetch_start in WRITE with mem_ready stalled 5 cycles -> write completes, then fetch issues, no underrun.
//  5 Second fetch_start before fetch_done -> underrun pulse, cnt=1; 300 such -> cnt=255; next_frame -> 0.
//  6 Random mem_ready/rvalid gaps, 3 lines -> banks alternate 0,1,0; all words in order; lb_rd_bank follows each fetch_done.

Source files
------------

// File: rtl/video_fetch_arbiter_if.sv
// rtl/video_fetch_arbiter_if.sv - memory command/response port shared by scan-out fetch and pixel writer
interface video_fetch_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic              mem_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/video_fetch_arbiter.sv
// rtl/video_fetch_arbiter.sv - scan-out line prefetch into a ping-pong line buffer, sharing RAM with a pixel writer
module video_fetch_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 480,
    parameter int FB_BASE    = 0,
    parameter int LB_AW      = 9
) (
    input  logic                 hdmi_clk,
    input  logic                 reset_n,
    input  logic                 fetch_start,
    input  logic [11:0]          fetch_line,
    input  logic                 next_frame,
    input  logic                 wr_valid,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    output logic                 wr_ready,
    video_fetch_arbiter_if.master mem,
    output logic                 lb_we,
    output logic [LB_AW:0]       lb_waddr,
    output logic [DATA_W-1:0]    lb_wdata,
    output logic                 lb_rd_bank,
    output logic                 fetch_done,
    output logic                 underrun,
    output logic [7:0]           underrun_cnt
);
    localparam int CNT_W = LB_AW + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

    state_t             state;
    logic               pending;
    logic               fetch_bank;
    logic               next_bank;
    logic               last_we;
    logic               done_bank;
    logic [11:0]        line_q;
    logic [CNT_W-1:0]   issue_cnt;
    logic [CNT_W-1:0]   rx_cnt;
    logic               fetch_active;
    logic               start_ok;
    logic               rx_ok;
    logic               overrun_evt;
    logic [ADDR_W-1:0]  line_base;

    // A fetch stays active until every issued read has come back, so a new line never reuses the counters early.
    assign fetch_active = pending || (state == FETCH) || (issue_cnt != rx_cnt);
    assign start_ok     = fetch_start && !fetch_active;
    assign overrun_evt  = fetch_start && fetch_active;
    assign rx_ok        = mem.mem_rvalid && (issue_cnt != rx_cnt);
    assign line_base    = ADDR_W'(FB_BASE) + ADDR_W'(line_q) * ADDR_W'(LINE_WORDS);

    // Writer is only granted from IDLE with nothing queued; a same-cycle fetch_start wins.
    assign wr_ready = reset_n && (state == IDLE) && !pending && !fetch_start && wr_valid;

    always_ff @(posedge hdmi_clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            pending       <= 1'b0;
            fetch_bank    <= 1'b0;
            next_bank     <= 1'b0;
            last_we       <= 1'b0;
            done_bank     <= 1'b0;
            line_q        <= '0;
            issue_cnt     <= '0;
            rx_cnt        <= '0;
            mem.mem_valid <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            lb_we         <= 1'b0;
            lb_waddr      <= '0;
            lb_wdata      <= '0;
            lb_rd_bank    <= 1'b0;
            fetch_done    <= 1'b0;
            underrun      <= 1'b0;
            underrun_cnt  <= '0;
        end else begin
            lb_we      <= 1'b0;
            last_we    <= 1'b0;
            fetch_done <= last_we;
            underrun   <= overrun_evt;
            if (last_we)
                lb_rd_bank <= done_bank;

            if (next_frame)
                underrun_cnt <= {7'd0, overrun_evt};
            else if (overrun_evt && underrun_cnt != 8'hFF)
                underrun_cnt <= underrun_cnt + 8'd1;

            if (rx_ok) begin
                lb_we    <= 1'b1;
                lb_waddr <= {fetch_bank, rx_cnt[LB_AW-1:0]};
                lb_wdata <= mem.mem_rdata;
                rx_cnt   <= rx_cnt + CNT_W'(1);
                if (rx_cnt == LAST_IDX) begin
                    last_we   <= 1'b1;
                    done_bank <= fetch_bank;
                end
            end

            case (state)
                IDLE: begin
                    if (pending) begin
                        state         <= FETCH;
                        pending       <= 1'b0;
                        mem.mem_valid <= 1'b1;
                        mem.mem_we    <= 1'b0;
                        mem.mem_addr  <= line_base;
                        mem.mem_wdata <= '0;
                    end else if (wr_ready) begin
                        state         <= WRITE;
                        mem.mem_valid <= 1'b1;
                        mem.mem_we    <= 1'b1;
                        mem.mem_addr  <= wr_addr;
                        mem.mem_wdata <= wr_data;
                    end
                end
                FETCH: begin
                    if (mem.mem_ready) begin
                        issue_cnt <= issue_cnt + CNT_W'(1);
                        if (issue_cnt == LAST_IDX) begin
                            mem.mem_valid <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            mem.mem_addr <= mem.mem_addr + ADDR_W'(1);
                        end
                    end
                end
                WRITE: begin
                    if (mem.mem_ready) begin
                        mem.mem_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (start_ok) begin
                line_q     <= fetch_line;
                fetch_bank <= next_bank;
                next_bank  <= ~next_bank;
                pending    <= 1'b1;
                issue_cnt  <= '0;
                rx_cnt     <= '0;
            end
        end
    end
endmodule
